// File: rtl/uart_io_regs.sv
// rtl/uart_io_regs.sv - CPU register block for UART character TX/RX FIFOs, baud divisor and echo control
// Optional feature: define UART_IO_RX_IRQ_EN to add the registered rx_irq output and CTRL[2] irq_en.
module uart_io_regs #(
    parameter logic [13:0] BASE_ADR      = 14'h0100,
    parameter int          TX_DEPTH_LOG2 = 3,
    parameter int          RX_DEPTH_LOG2 = 3,
    parameter logic [15:0] TERM_DEFAULT  = 16'd54
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_we,
    input  logic [13:0] io_wadr,
    input  logic [31:0] io_wdata,
    input  logic        io_radr_en,
    input  logic [13:0] io_radr,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_io_char,
    output logic        uart_io_we,
    input  logic        uart_io_full,
    input  logic [7:0]  rout,
    input  logic        rout_en,
    output logic [15:0] uart_term,
    output logic        rx_disable_echoback
`ifdef UART_IO_RX_IRQ_EN
    ,
    output logic        rx_irq
`endif
);

    localparam logic [13:0] OFF_TX   = 14'd0;
    localparam logic [13:0] OFF_RX   = 14'd1;
    localparam logic [13:0] OFF_ST   = 14'd2;
    localparam logic [13:0] OFF_CTRL = 14'd3;
    localparam logic [13:0] OFF_TERM = 14'd4;
    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;

    typedef enum logic {IDLE, ISSUE} tx_state_t;
    tx_state_t tx_state;

    logic [7:0] tx_mem [TXD];
    logic [7:0] rx_mem [RXD];
    logic [TX_DEPTH_LOG2:0] tx_wptr, tx_rptr, tx_count;
    logic [RX_DEPTH_LOG2:0] rx_wptr, rx_rptr, rx_count;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_ovf, rx_ovf, rx_en, irq_en;
    logic [13:0] woff, roff;
    logic        wr_tx, wr_st, wr_ctrl, wr_term, rd_rx;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic [31:0] status, rdata_next;
    logic        unused_wdata;

    assign unused_wdata = ^io_wdata[31:16];

    assign woff    = io_wadr - BASE_ADR;
    assign roff    = io_radr - BASE_ADR;
    assign wr_tx   = io_we && (woff == OFF_TX);
    assign wr_st   = io_we && (woff == OFF_ST);
    assign wr_ctrl = io_we && (woff == OFF_CTRL);
    assign wr_term = io_we && (woff == OFF_TERM);
    assign rd_rx   = io_radr_en && (roff == OFF_RX);

    // Pointers carry one extra bit so equal low bits with differing MSB means full.
    assign tx_count = tx_wptr - tx_rptr;
    assign rx_count = rx_wptr - rx_rptr;
    assign tx_empty = (tx_wptr == tx_rptr);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign tx_full  = (tx_wptr[TX_DEPTH_LOG2] != tx_rptr[TX_DEPTH_LOG2]) &&
                      (tx_wptr[TX_DEPTH_LOG2-1:0] == tx_rptr[TX_DEPTH_LOG2-1:0]);
    assign rx_full  = (rx_wptr[RX_DEPTH_LOG2] != rx_rptr[RX_DEPTH_LOG2]) &&
                      (rx_wptr[RX_DEPTH_LOG2-1:0] == rx_rptr[RX_DEPTH_LOG2-1:0]);

    assign tx_push = wr_tx && !tx_full;
    assign tx_pop  = (tx_state == IDLE) && !tx_empty && !uart_io_full;
    assign rx_pop  = rd_rx && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign rx_push = rout_en && rx_en && (!rx_full || rx_pop);
    assign rx_drop = rout_en && rx_en && rx_full && !rx_pop;

`ifndef UART_IO_RX_IRQ_EN
    assign irq_en = 1'b0;
`endif

    always_comb begin
        status        = '0;
        status[0]     = !rx_empty;
        status[1]     = tx_full;
        status[2]     = tx_empty;
        status[3]     = rx_ovf;
        status[4]     = tx_ovf;
        status[11:8]  = 4'(rx_count);
        status[19:16] = 4'(tx_count);
    end

    always_comb begin
        rdata_next = '0;
        if (io_radr_en) begin
            case (roff)
                OFF_RX:   if (!rx_empty) rdata_next = {23'd0, 1'b1, rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]]};
                OFF_ST:   rdata_next = status;
                OFF_CTRL: rdata_next = {29'd0, irq_en, rx_disable_echoback, rx_en};
                OFF_TERM: rdata_next = {16'd0, uart_term};
                default:  rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= io_wdata[7:0];
        if (rx_push) rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state            <= IDLE;
            tx_wptr             <= '0;
            tx_rptr             <= '0;
            rx_wptr             <= '0;
            rx_rptr             <= '0;
            tx_ovf              <= 1'b0;
            rx_ovf              <= 1'b0;
            rx_en               <= 1'b1;
            rx_disable_echoback <= 1'b0;
            uart_term           <= TERM_DEFAULT;
            io_rdata            <= '0;
            uart_io_char        <= '0;
            uart_io_we          <= 1'b0;
`ifdef UART_IO_RX_IRQ_EN
            irq_en              <= 1'b0;
            rx_irq              <= 1'b0;
`endif
        end else begin
            io_rdata <= rdata_next;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;

            case (tx_state)
                IDLE: begin
                    if (tx_pop) begin
                        uart_io_char <= tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];
                        uart_io_we   <= 1'b1;
                        tx_rptr      <= tx_rptr + 1'b1;
                        tx_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    uart_io_we <= 1'b0;
                    tx_state   <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase

            // A fresh overflow wins over a same-cycle W1C clear.
            tx_ovf <= (tx_ovf && !(wr_st && io_wdata[4])) || (wr_tx && tx_full);
            rx_ovf <= (rx_ovf && !(wr_st && io_wdata[3])) || rx_drop;

            if (wr_ctrl) begin
                rx_en               <= io_wdata[0];
                rx_disable_echoback <= io_wdata[1];
`ifdef UART_IO_RX_IRQ_EN
                irq_en              <= io_wdata[2];
`endif
            end
            if (wr_term) uart_term <= io_wdata[15:0];
`ifdef UART_IO_RX_IRQ_EN
            rx_irq <= irq_en && (!rx_empty || rx_ovf);
`endif
        end
    end

endmodule
